// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//
// Two-requester round-robin arbiter for the shared register-file write-back
// port. It picks a winner, drives the write-back mux select, and captures the
// selected word into a one-entry output register with a valid/ready handshake.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   reset      - synchronous, active-low reset (0 = in reset)
//   req[1:0]   - requester offers; data held stable until acked
//   din0/din1  - requester 0 / 1 data (WIDTH bits)
//   ack[1:0]   - combinational one-hot capture acknowledge
//   sel        - combinational mux select (0 = din0, 1 = din1)
//   out_valid  - output register holds a word
//   out_data   - registered winner data
//   out_src    - index of the requester that produced out_data
//   out_ready  - downstream accepts out_data at this edge when out_valid=1
//   gnt_cnt0/1 - saturating per-requester grant counters (CNTW bits)
//
// Build option:
//   WB_ARB_FIXED_PRIO_EN - when defined, requester 0 always wins ties;
//                          otherwise ties alternate round-robin.

module wb_port_arbiter #(
  parameter int WIDTH = 64,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic [1:0]       ack,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNTW-1:0]  gnt_cnt0,
  output logic [CNTW-1:0]  gnt_cnt1
);

  // Saturating increment: holds at all-ones.
  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (c == {CNTW{1'b1}}) ? c : c + CNTW'(1);
  endfunction

  logic last;
  logic load_en;
  logic winner;

  always_comb begin
    load_en = ~out_valid | out_ready;
    // With no request the winner defaults to last, so sel stays put while idle.
    winner  = last;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
`ifdef WB_ARB_FIXED_PRIO_EN
      2'b11:   winner = 1'b0;
`else
      2'b11:   winner = ~last;
`endif
      default: winner = last;
    endcase
    sel = winner;
    ack = 2'b00;
    // Reset gates ack so nothing is captured on a reset edge.
    if (reset && load_en && (req != 2'b00)) ack[winner] = 1'b1;
  end

  // Output register stage
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
      last      <= 1'b1;
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
    end else if (ack != 2'b00) begin
      out_data  <= sel ? din1 : din0;
      out_src   <= winner;
      out_valid <= 1'b1;
      last      <= winner;
      if (winner) gnt_cnt1 <= sat_inc(gnt_cnt1);
      else        gnt_cnt0 <= sat_inc(gnt_cnt0);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter: a default-size instance covers
// reset, backpressure, single requester, contention, drain and mid-transfer
// reset; a CNTW=2 instance covers grant-counter saturation.

module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic        reset, out_ready, sel, out_valid, out_src;
  logic [1:0]  req, ack;
  logic [63:0] din0, din1, out_data;
  logic [7:0]  gnt_cnt0, gnt_cnt1;

  wb_port_arbiter #(.WIDTH(64), .CNTW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .din0(din0), .din1(din1),
    .ack(ack), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  // Saturation instance
  logic        s_reset, s_ready, s_sel, s_valid, s_src;
  logic [1:0]  s_req, s_ack;
  logic [63:0] s_din0, s_din1, s_data;
  logic [1:0]  s_cnt0, s_cnt1;

  wb_port_arbiter #(.WIDTH(64), .CNTW(2)) dut_sat (
    .clk(clk), .reset(s_reset), .req(s_req), .din0(s_din0), .din1(s_din1),
    .ack(s_ack), .sel(s_sel), .out_valid(s_valid), .out_data(s_data),
    .out_src(s_src), .out_ready(s_ready),
    .gnt_cnt0(s_cnt0), .gnt_cnt1(s_cnt1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] DA = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] DB = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] DS = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] DC = 64'h0000_0000_0000_00C0;
  localparam logic [63:0] DD = 64'h0000_0000_0000_00D0;

`ifdef WB_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  initial begin
    logic       exp_src;
    logic [7:0] e0, e1;
    logic       exp_last;

    reset = 1'b0; req = 2'b11; din0 = DA; din1 = DB; out_ready = 1'b0;
    s_reset = 1'b0; s_req = 2'b00; s_din0 = '0; s_din1 = '0; s_ready = 1'b1;

    // Reset held for two cycles with both requests up
    tick();
    tick();
    chk("rst_ack", ack, 2'b00);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_cnt0", gnt_cnt0, 8'd0);
    chk("rst_cnt1", gnt_cnt1, 8'd0);

    // First edge after release: requester 0 wins the tie
    reset = 1'b1;
    #1;
    chk("first_ack", ack, 2'b01);
    chk("first_sel", sel, 1'b0);
    tick();
    chk("first_valid", out_valid, 1'b1);
    chk("first_data", out_data, DA);
    chk("first_src", out_src, 1'b0);
    chk("first_cnt0", gnt_cnt0, 8'd1);

    // Backpressure: out_ready low for 3 cycles, nothing acked, word stable
    din0 = DC;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ack", ack, 2'b00);
      tick();
      chk("bp_data", out_data, DA);
      chk("bp_valid", out_valid, 1'b1);
    end

    // Ready rises: drain and load on the same edge
    out_ready = 1'b1;
    #1;
    exp_src = FIXED ? 1'b0 : 1'b1;
    chk("bp_rel_ack", ack, FIXED ? 2'b01 : 2'b10);
    tick();
    chk("bp_rel_valid", out_valid, 1'b1);
    chk("bp_rel_data", out_data, FIXED ? DC : DB);
    chk("bp_rel_src", out_src, exp_src);
    e0 = FIXED ? 8'd2 : 8'd1;
    e1 = FIXED ? 8'd0 : 8'd1;
    chk("bp_rel_cnt0", gnt_cnt0, e0);
    chk("bp_rel_cnt1", gnt_cnt1, e1);

    // Single requester 1
    req = 2'b10; din1 = DS;
    #1;
    chk("single_ack", ack, 2'b10);
    chk("single_sel", sel, 1'b1);
    tick();
    chk("single_data", out_data, DS);
    chk("single_src", out_src, 1'b1);
    e1 = e1 + 8'd1;
    chk("single_cnt1", gnt_cnt1, e1);

    // Sustained contention: last=1 so RR gives 0,1,0,1,0,1
    req = 2'b11; din0 = DC; din1 = DD;
    for (int i = 0; i < 6; i++) begin
      exp_src = FIXED ? 1'b0 : 1'(i % 2);
      #1;
      chk("cont_ack", ack, exp_src ? 2'b10 : 2'b01);
      tick();
      chk("cont_src", out_src, exp_src);
      chk("cont_data", out_data, exp_src ? DD : DC);
    end
    e0 = e0 + (FIXED ? 8'd6 : 8'd3);
    e1 = e1 + (FIXED ? 8'd0 : 8'd3);
    chk("cont_cnt0", gnt_cnt0, e0);
    chk("cont_cnt1", gnt_cnt1, e1);
    exp_last = FIXED ? 1'b0 : 1'b1;

    // Drain only
    req = 2'b00;
    #1;
    chk("drain_ack", ack, 2'b00);
    chk("drain_sel", sel, exp_last);
    tick();
    chk("drain_valid", out_valid, 1'b0);
    chk("drain_data", out_data, exp_last ? DD : DC);
    chk("drain_src", out_src, exp_last);
    chk("idle_sel", sel, exp_last);

    // Mid-transfer reset discards the pending word
    req = 2'b01; din0 = DA;
    tick();
    chk("mid_valid", out_valid, 1'b1);
    chk("mid_data", out_data, DA);
    out_ready = 1'b0; req = 2'b11; reset = 1'b0;
    #1;
    chk("mid_rst_ack", ack, 2'b00);
    tick();
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 64'h0);
    chk("mid_rst_cnt0", gnt_cnt0, 8'd0);
    chk("mid_rst_cnt1", gnt_cnt1, 8'd0);
    reset = 1'b1; req = 2'b00;

    // Saturation with CNTW=2: five grants to requester 0
    s_reset = 1'b1; s_req = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      s_din0 = 64'(k);
      #1;
      chk("sat_ack", s_ack, 2'b01);
      tick();
      chk("sat_data", s_data, 64'(k));
      chk("sat_cnt0", s_cnt0, (k >= 3) ? 2'd3 : 2'(k));
    end
    chk("sat_valid", s_valid, 1'b1);
    chk("sat_cnt1", s_cnt1, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
